// File: rtl/w_store_ctrl.sv
// Residue (W) store sequencer for the online divider. Each enabled iteration
// reads residue j and writes residue j+1, and flags one quotient digit once warm-up is over.
`timescale 1ns/1ps
module w_store_ctrl #(
    parameter int ADDR_WIDTH   = 7,
    parameter int ONLINE_DELAY = 3,
    parameter int MAX_DIGITS   = 2**ADDR_WIDTH - 1 - ONLINE_DELAY
) (
    input  logic                  clk,
    input  logic                  asyn_reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_digits,
    input  logic                  stall,
    input  logic                  abort,
    output logic                  busy,
    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  q_valid,
    output logic [ADDR_WIDTH-1:0] q_index,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DELAY_W   = ADDR_WIDTH'(ONLINE_DELAY);
    localparam logic [ADDR_WIDTH-1:0] MAX_W     = ADDR_WIDTH'(MAX_DIGITS);
    localparam logic [ADDR_WIDTH-1:0] WARM_LAST =
        ADDR_WIDTH'((ONLINE_DELAY == 0) ? 0 : ONLINE_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   j_q, j_d;
    logic [ADDR_WIDTH-1:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0]   t_q, t_d;
    logic [ADDR_WIDTH-1:0]   n_clamped;

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            n_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            n_q     <= n_d;
            t_q     <= t_d;
        end
    end

    // Clamping keeps the last write address inside the store, so j+1 never wraps.
    assign n_clamped = (num_digits > MAX_W) ? MAX_W : num_digits;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        n_d     = n_q;
        t_d     = t_q;

        busy    = (state_q != IDLE);
        enable  = ((state_q == WARMUP) || (state_q == RUN)) && !stall && !abort;
        q_valid = enable && (state_q == RUN);
        q_index = q_valid ? (j_q - DELAY_W) : '0;
        done    = (state_q == DONE) && !abort;
        rd_addr = j_q;
        wr_addr = j_q + ONE;

        if (enable) begin
            j_d = j_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n_clamped;
                    state_d = (n_clamped != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                j_d     = '0;
                t_d     = n_q + DELAY_W;
                state_d = (ONLINE_DELAY == 0) ? RUN : WARMUP;
            end
            WARMUP: begin
                if (enable && (j_q == WARM_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (enable && (j_q == t_q - ONE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                j_d     = '0;
                state_d = IDLE;
            end
            default: begin
                j_d     = '0;
                state_d = IDLE;
            end
        endcase

        // Abort outranks stall and every transition above; IDLE ignores it so start wins.
        if (abort && (state_q != IDLE)) begin
            j_d     = '0;
            state_d = IDLE;
        end
    end

endmodule
